// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, redirect/halt FSM and the IF/ID pipeline register.
// Define FETCH_PERF_EN to add the saturating redirect/stall performance counters.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        br_taken_i,
    input  logic [63:0] br_target_i,
    input  logic        halt_i,
    input  logic        id_ready_i,
    output logic [63:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [63:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_redirects_o,
    output logic [31:0] perf_stalls_o,
`endif
    output logic        misalign_err_o
);

    typedef enum logic [1:0] {StRun, StBubble, StHalt} state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [63:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic        if_id_valid_q;
    logic        misalign_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else if (br_taken_i) begin
            state_q       <= StBubble;
            pc_q          <= {br_target_i[63:2], 2'b00};
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            if (br_target_i[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
        end else if (halt_i || state_q == StHalt) begin
            // PC frozen; a valid entry leaves only when decode takes it.
            state_q <= StHalt;
            if (id_ready_i) begin
                if_id_valid_q <= 1'b0;
            end
        end else if (id_ready_i) begin
            state_q       <= StRun;
            pc_q          <= pc_q + 64'd4;
            if_id_pc_q    <= pc_q;
            if_id_instr_q <= imem_rdata_i;
            if_id_valid_q <= 1'b1;
        end
    end

    assign imem_addr_o    = pc_q;
    assign if_id_pc_o     = if_id_pc_q;
    assign if_id_instr_o  = if_id_instr_q;
    assign if_id_valid_o  = if_id_valid_q;
    assign misalign_err_o = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects_q;
    logic [31:0] perf_stalls_q;
    logic        stall;

    assign stall = !br_taken_i && !halt_i && !id_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_redirects_q <= 32'h0;
            perf_stalls_q    <= 32'h0;
        end else begin
            if (br_taken_i && perf_redirects_q != 32'hFFFF_FFFF) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
            if (stall && if_id_valid_q && perf_stalls_q != 32'hFFFF_FFFF) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_redirects_o = perf_redirects_q;
    assign perf_stalls_o    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then randomized traffic against a fetch-rule model.
module tb_fetch_pc_unit;

    localparam logic [63:0] RstPc = 64'h1000;
    localparam logic [31:0] Nop   = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_taken;
    logic [63:0] br_target;
    logic        halt;
    logic        id_ready;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the fetch rules say the outputs should be.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted, m_err;
    longint unsigned m_redir, m_stalls;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[33:2] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_pc_unit #(
        .RESET_PC (RstPc),
        .NOP_INSTR(Nop)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .halt_i        (halt),
        .id_ready_i    (id_ready),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .if_id_pc_o    (if_id_pc),
        .if_id_instr_o (if_id_instr),
        .if_id_valid_o (if_id_valid),
`ifdef FETCH_PERF_EN
        .perf_redirects_o(perf_redirects),
        .perf_stalls_o   (perf_stalls),
`endif
        .misalign_err_o(misalign_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RstPc; m_ipc = 64'h0; m_instr = Nop;
        m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        m_redir = 0; m_stalls = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr,    m_pc);
        check({tag, ".pc"},    if_id_pc,     m_ipc);
        check({tag, ".instr"}, {32'h0, if_id_instr}, {32'h0, m_instr});
        check({tag, ".valid"}, {63'h0, if_id_valid},  {63'h0, m_valid});
        check({tag, ".err"},   {63'h0, misalign_err}, {63'h0, m_err});
`ifdef FETCH_PERF_EN
        check({tag, ".predir"}, {32'h0, perf_redirects},
              (m_redir > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_redir);
        check({tag, ".pstall"}, {32'h0, perf_stalls},
              (m_stalls > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stalls);
`endif
    endtask

    // Apply the current inputs across one rising edge, advance the model, compare at edge+1.
    task automatic cycle(input string tag);
        logic [63:0] n_pc, n_ipc;
        logic [31:0] n_instr;
        logic        n_valid, n_halted, n_err;
        n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr;
        n_valid = m_valid; n_halted = m_halted; n_err = m_err;
        if (br_taken) begin
            n_pc = br_target & ~64'h3;
            n_valid = 1'b0; n_instr = Nop; n_halted = 1'b0;
            if (br_target % 4 != 0) n_err = 1'b1;
            m_redir++;
        end else if (halt || m_halted) begin
            n_halted = 1'b1;
            if (id_ready) n_valid = 1'b0;
        end else if (id_ready) begin
            n_ipc = m_pc; n_instr = mem_word(m_pc); n_valid = 1'b1; n_pc = m_pc + 64'd4;
        end
        if (!br_taken && !halt && !id_ready && m_valid) m_stalls++;
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr;
        m_valid = n_valid; m_halted = n_halted; m_err = n_err;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        br_taken = 1'b0; br_target = 64'h0; halt = 1'b0; id_ready = 1'b1;
    endtask

    // Reset pulse placed between clock edges; outputs must react without a clock.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Sequential fetch from RESET_PC.
        for (int i = 0; i < 3; i++) cycle("seq");
        check("seq.pc_last", if_id_pc, 64'h1008);
        check("seq.addr_last", imem_addr, 64'h100C);

        // Stall holds a valid entry.
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle("stall");
        check("stall.pc_held", if_id_pc, 64'h1008);
        check("stall.addr_held", imem_addr, 64'h100C);

        // Aligned redirect, then the bubble fetch.
        id_ready = 1'b1; br_taken = 1'b1; br_target = 64'h2000;
        cycle("br");
        check("br.valid0", {63'h0, if_id_valid}, 64'h0);
        br_taken = 1'b0;
        cycle("bubble");
        check("bubble.pc", if_id_pc, 64'h2000);

        // Misaligned redirect sets the sticky error.
        br_taken = 1'b1; br_target = 64'h2003;
        cycle("mis");
        check("mis.addr", imem_addr, 64'h2000);
        br_target = 64'h3000;
        cycle("mis.sticky");
        br_taken = 1'b0;
        cycle("mis.after");

        // PC wrap, halt, then resume via redirect.
        br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle("wrap.br");
        br_taken = 1'b0;
        cycle("wrap.adv");
        check("wrap.addr0", imem_addr, 64'h0);
        halt = 1'b1;
        cycle("halt");
        halt = 1'b0;
        for (int i = 0; i < 3; i++) cycle("halted");
        check("halt.frozen", imem_addr, 64'h0);
        br_taken = 1'b1; br_target = 64'h40;
        cycle("resume.br");
        br_taken = 1'b0;
        cycle("resume");
        check("resume.pc", if_id_pc, 64'h40);

        // Redirect while decode stalls, then reset in the middle of the bubble.
        cycle("pre_flush");
        br_taken = 1'b1; br_target = 64'h800; id_ready = 1'b0;
        cycle("flush");
        br_taken = 1'b0;
        async_reset("rst_bubble");
        cycle("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            br_taken = ($urandom_range(0, 9) == 0);
            br_target = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) br_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) br_target = 64'hFFFF_FFFF_FFFF_FFF0;
            halt = ($urandom_range(0, 19) == 0);
            id_ready = ($urandom_range(0, 9) < 7);
            cycle("rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand.rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
